// File: rtl/snd_pdm_decimator_pkg.sv
// Shared sizing helpers for the PDM-to-PCM CIC decimator.
package snd_pdm_decimator_pkg;

    // Accumulator width that holds DECIM^ORDER without loss, plus one bit.
    function automatic int cic_acc_w(input int decim, input int order);
        return (order * $clog2(decim)) + 32'sd1;
    endfunction

    // True when v is a positive power of two.
    function automatic bit is_pow2(input int v);
        return (v > 32'sd0) && ((v & (v - 32'sd1)) == 32'sd0);
    endfunction

    // Legal parameter set for the decimator.
    function automatic bit cfg_ok(input int decim, input int order, input int out_bits);
        return is_pow2(decim) && (decim >= 32'sd4) &&
               (order >= 32'sd1) && (order <= 32'sd4) &&
               (out_bits >= 32'sd1) && (out_bits <= (cic_acc_w(decim, order) - 32'sd1));
    endfunction

endpackage

// File: rtl/snd_pdm_decimator_comb.sv
// One registered CIC comb stage: on en, y <= x - previous x (modulo 2^W).
module snd_cic_comb
    import snd_pdm_decimator_pkg::*;
#(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;
    logic [W-1:0] y_q;
    logic [W-1:0] y_d;

    // Difference against the value captured at the previous enable.
    always_comb begin
        prev_d = prev_q;
        y_d    = y_q;
        if (en) begin
            y_d    = x - prev_q;
            prev_d = x;
        end else begin
            y_d    = y_q;
        end
    end

    // Stage state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= {W{1'b0}};
            y_q    <= {W{1'b0}};
        end else begin
            prev_q <= prev_d;
            y_q    <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/snd_pdm_decimator.sv
// CIC decimator turning the 1-bit snd stream into unsigned PCM samples
// behind a single-entry valid/ready output register.
module snd_pdm_decimator
    import snd_pdm_decimator_pkg::*;
#(
    parameter int DECIM    = 256,
    parameter int ORDER    = 3,
    parameter int OUT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                snd_in,
    output logic [OUT_BITS-1:0] sample,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun
);

    localparam int ACC_W  = cic_acc_w(DECIM, ORDER);
    localparam int CNT_W  = $clog2(DECIM);
    localparam int WARM_W = $clog2(ORDER + 1);

    if (!cfg_ok(DECIM, ORDER, OUT_BITS)) begin : g_bad_cfg
        $error("snd_pdm_decimator: illegal DECIM/ORDER/OUT_BITS combination");
    end

    logic [ACC_W-1:0]    integ_q [ORDER];
    logic [ACC_W-1:0]    integ_d [ORDER];
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [ORDER-1:0]    en_q;
    logic [ORDER-1:0]    en_d;
    logic [WARM_W-1:0]   warm_q;
    logic [WARM_W-1:0]   warm_d;
    logic [OUT_BITS-1:0] sample_q;
    logic [OUT_BITS-1:0] sample_d;
    logic                valid_q;
    logic                valid_d;
    logic                overrun_q;
    logic                overrun_d;

    logic [ACC_W-1:0]    comb_y_s [ORDER];
    logic                strobe_s;
    logic                res_s;
    logic                keep_s;
    logic [ACC_W-1:0]    r_s;
    logic [OUT_BITS-1:0] sample_new_s;

    // Integrator cascade and decimation counter; both wrap by design.
    always_comb begin
        integ_d[0] = integ_q[0] + {{(ACC_W-1){1'b0}}, snd_in};
        for (int k = 1; k < ORDER; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        strobe_s = (cnt_q == {CNT_W{1'b1}});
    end

    // Enable token walking down the comb stages, one stage per cycle.
    always_comb begin
        en_d[0] = strobe_s;
        for (int k = 1; k < ORDER; k++) begin
            en_d[k] = en_q[k-1];
        end
    end

    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        if (g == 0) begin : g_first
            snd_cic_comb #(.W(ACC_W)) u_comb (
                .clk   (clk),
                .reset (reset),
                .en    (strobe_s),
                .x     (integ_q[ORDER-1]),
                .y     (comb_y_s[0])
            );
        end else begin : g_next
            snd_cic_comb #(.W(ACC_W)) u_comb (
                .clk   (clk),
                .reset (reset),
                .en    (en_q[g-1]),
                .x     (comb_y_s[g-1]),
                .y     (comb_y_s[g])
            );
        end
    end

    // Full-scale input gives exactly 2^(ACC_W-1), which is clipped to the top code.
    assign r_s = comb_y_s[ORDER-1];
    always_comb begin
        if (r_s[ACC_W-1]) begin
            sample_new_s = {OUT_BITS{1'b1}};
        end else begin
            sample_new_s = r_s[ACC_W-2 -: OUT_BITS];
        end
    end

    if (ACC_W - 1 > OUT_BITS) begin : g_trunc
        logic unused_lo_s;
        assign unused_lo_s = ^r_s[ACC_W-OUT_BITS-2:0];
    end

    // Warm-up gating and single-entry output register with drop-on-full.
    always_comb begin
        res_s     = en_q[ORDER-1];
        keep_s    = res_s && (warm_q == WARM_W'(ORDER));
        warm_d    = warm_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (res_s && (warm_q != WARM_W'(ORDER))) begin
            warm_d = warm_q + {{(WARM_W-1){1'b0}}, 1'b1};
        end else begin
            warm_d = warm_q;
        end
        if (keep_s) begin
            if (!valid_q || out_ready) begin
                sample_d = sample_new_s;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // All state, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= {ACC_W{1'b0}};
            end
            cnt_q     <= {CNT_W{1'b0}};
            en_q      <= {ORDER{1'b0}};
            warm_q    <= {WARM_W{1'b0}};
            sample_q  <= {OUT_BITS{1'b0}};
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
            end
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            warm_q    <= warm_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample    = sample_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_snd_pdm_decimator.sv
// Self-checking bench for snd_pdm_decimator (DECIM=256, ORDER=3, OUT_BITS=16).
module tb_snd_pdm_decimator;

    localparam int D     = 256;
    localparam int ORD   = 3;
    localparam int HMAX  = 8192;
    localparam longint FULL = 64'd16777216;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        snd_in = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] sample;
    logic        out_valid;
    logic        overrun;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // model state
    int          ecnt = 0;
    bit          hist [HMAX];
    logic        m_valid = 1'b0;
    logic [15:0] m_sample = 16'h0000;
    logic        m_ovr = 1'b0;

    snd_pdm_decimator #(.DECIM(D), .ORDER(ORD), .OUT_BITS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .snd_in    (snd_in),
        .sample    (sample),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // Response of a third-order integrator chain to a unit input d edges ago.
    function automatic longint g3(input longint d);
        if (d <= 0) return 0;
        return d * (d - 1) / 2;
    endfunction

    // CIC kernel: third D-spaced difference of the integrator response.
    function automatic longint wgt(input longint d);
        return g3(d) - 3 * g3(d - D) + 3 * g3(d - 2 * D) - g3(d - 3 * D);
    endfunction

    // Filter output for the integrator value as it stood after edge t.
    function automatic longint cic_result(input int t);
        longint acc = 0;
        int lo = t - 3 * D - 2;
        if (lo < 1) lo = 1;
        for (int i = lo; i <= t; i++) begin
            if (hist[i]) acc += wgt(t - i);
        end
        return acc;
    endfunction

    // Behavioural model, advanced on every rising edge.
    always @(posedge clk) begin : model
        int e;
        int m;
        longint r;
        logic [15:0] s;
        if (reset) begin
            ecnt     <= 0;
            m_valid  <= 1'b0;
            m_sample <= 16'h0000;
            m_ovr    <= 1'b0;
        end else begin
            e = ecnt + 1;
            ecnt <= e;
            if (e < HMAX) hist[e] <= snd_in;
            m = (e - 3) / D;
            if ((e > 3) && ((e - 3) % D == 0) && (m > ORD)) begin
                r = cic_result(e - 4);
                if (r >= FULL) s = 16'hFFFF;
                else s = 16'(r >> 8);
                if (!m_valid || out_ready) begin
                    m_sample <= s;
                    m_valid  <= 1'b1;
                end else begin
                    m_ovr <= 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
            check("sample", {16'd0, sample}, {16'd0, m_sample});
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // mode 0 hold, 1 toggle, 2 random with density dens percent.
    task automatic run_to(input int target, input int mode, input int dens, input bit rnd_ready);
        int guard = 0;
        while (ecnt < target && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
            case (mode)
                1: snd_in = ~snd_in;
                2: snd_in = ($urandom_range(0, 99) < dens);
                default: ;
            endcase
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (ecnt != target) begin
            n_checks++;
            $display("FAIL reach_edge: got %0d expected %0d", ecnt, target);
        end
    endtask

    initial begin
        // 1: all-zero input, first sample timing
        snd_in = 1'b0;
        out_ready = 1'b1;
        do_reset();
        cmp_en = 1'b1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_sample", {16'd0, sample}, 32'd0);
        run_to(1026, 0, 0, 1'b0);
        check("s1_no_valid_1026", {31'd0, out_valid}, 32'd0);
        run_to(1027, 0, 0, 1'b0);
        check("s1_valid_1027", {31'd0, out_valid}, 32'd1);
        check("s1_sample", {16'd0, sample}, 32'h0000);
        run_to(1027 + 2 * D, 0, 0, 1'b0);
        check("s1_sample_late", {16'd0, sample}, 32'h0000);

        // 2: all-one input saturates
        snd_in = 1'b1;
        do_reset();
        run_to(1027, 0, 0, 1'b0);
        check("s2_sample", {16'd0, sample}, 32'hFFFF);
        run_to(1027 + 2 * D, 0, 0, 1'b0);
        check("s2_valid", {31'd0, out_valid}, 32'd1);
        check("s2_sample_late", {16'd0, sample}, 32'hFFFF);
        check("s2_overrun", {31'd0, overrun}, 32'd0);

        // 3: alternating input lands exactly on mid-scale
        snd_in = 1'b0;
        do_reset();
        run_to(1027, 1, 0, 1'b0);
        check("s3_sample", {16'd0, sample}, 32'h8000);
        run_to(1539, 1, 0, 1'b0);
        check("s3_sample_late", {16'd0, sample}, 32'h8000);

        // 4: backpressure across two results, then ready on a landing cycle
        out_ready = 1'b0;
        snd_in = 1'b1;
        run_to(1795, 0, 0, 1'b0);
        check("s4_held_valid", {31'd0, out_valid}, 32'd1);
        check("s4_held_sample", {16'd0, sample}, 32'h8000);
        check("s4_overrun", {31'd0, overrun}, 32'd1);
        run_to(2050, 0, 0, 1'b0);
        out_ready = 1'b1;
        run_to(2051, 0, 0, 1'b0);
        check("s4_valid_kept", {31'd0, out_valid}, 32'd1);
        check("s4_new_loaded", {31'd0, (sample != 16'h8000)}, 32'd1);
        check("s4_overrun_sticky", {31'd0, overrun}, 32'd1);

        // 5: reset mid-frame while a sample is held
        run_to(2100, 0, 0, 1'b0);
        out_ready = 1'b0;
        run_to(2400, 0, 0, 1'b0);
        check("s5_pre_valid", {31'd0, out_valid}, 32'd1);
        do_reset();
        check("s5_valid", {31'd0, out_valid}, 32'd0);
        check("s5_overrun", {31'd0, overrun}, 32'd0);
        check("s5_sample", {16'd0, sample}, 32'd0);
        out_ready = 1'b1;
        run_to(1026, 2, 30, 1'b0);
        check("s5_no_valid_1026", {31'd0, out_valid}, 32'd0);
        run_to(1027, 2, 30, 1'b0);
        check("s5_valid_1027", {31'd0, out_valid}, 32'd1);

        // 6: varying-density input with random backpressure
        for (int k = 0; k < 6; k++) begin
            run_to(1027 + (k + 1) * D, 2, 10 + 15 * k, 1'b1);
        end
        out_ready = 1'b1;
        run_to(1027 + 7 * D + 4, 2, 50, 1'b0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
